// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package btn_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        HELD       = 2'd2,
        WAIT_REL   = 2'd3
    } btn_state_t;

    // Default timings, in 1 ms ticks.
    localparam int BTN_DEB_MS          = 20;
    localparam int BTN_REPEAT_DELAY_MS = 500;
    localparam int BTN_REPEAT_RATE_MS  = 100;

    // Larger of two integers; sizes the auto-repeat counter.
    function automatic int btn_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, press/release FSM, debounce
// counter and optional auto-repeat (BTN_REPEAT_EN).
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | button released and accepted as released
// WAIT_PRESS | synchronised input high, counting ticks toward a press
// HELD       | press accepted; auto-repeat runs here when enabled
// WAIT_REL   | synchronised input low, counting ticks toward a release
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEB_MS          = BTN_DEB_MS,
    parameter int REPEAT_DELAY_MS = BTN_REPEAT_DELAY_MS,
    parameter int REPEAT_RATE_MS  = BTN_REPEAT_RATE_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int              CW       = $clog2(DEB_MS + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_MS - 1);

    logic          sync_meta;
    logic          s;
    btn_state_t    state_q;
    btn_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_acc;
    logic          release_d;
    logic          level_d;
    logic          rep_fire;

    // Two-flop synchroniser for the raw asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 1'b0;
            s         <= 1'b0;
        end else begin
            sync_meta <= i_btn;
            s         <= sync_meta;
        end
    end

    // FSM state and debounce counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter; a level change always beats a coincident tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_acc = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (i_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = HELD;
                        cnt_d     = '0;
                        press_acc = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            HELD: begin
                cnt_d = '0;
                if (!s) begin
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (i_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Level follows the state we are about to enter, so it moves with the pulses.
    always_comb begin
        level_d = (state_d == HELD) || (state_d == WAIT_REL);
    end

`ifdef BTN_REPEAT_EN
    localparam int            RW             = $clog2(btn_max(REPEAT_DELAY_MS, REPEAT_RATE_MS) + 1);
    localparam logic [RW-1:0] REP_DELAY_LAST = RW'(REPEAT_DELAY_MS - 1);
    localparam logic [RW-1:0] REP_RATE_LAST  = RW'(REPEAT_RATE_MS - 1);

    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;
    logic          rphase_q;
    logic          rphase_d;

    // Repeat counter registers; rphase_q set once the initial delay has elapsed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q   <= '0;
            rphase_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            rphase_q <= rphase_d;
        end
    end

    // Count ticks only while staying in HELD; any exit restarts the delay phase.
    always_comb begin
        rcnt_d   = rcnt_q;
        rphase_d = rphase_q;
        rep_fire = 1'b0;
        if (state_d != HELD) begin
            rcnt_d   = '0;
            rphase_d = 1'b0;
        end else if ((state_q == HELD) && i_tick) begin
            if (rcnt_q == (rphase_q ? REP_RATE_LAST : REP_DELAY_LAST)) begin
                rep_fire = 1'b1;
                rcnt_d   = '0;
                rphase_d = 1'b1;
            end else begin
                rcnt_d = rcnt_q + RW'(1);
            end
        end
    end
`else
    // Repeat timings only matter when auto-repeat is built in.
    localparam int unused_repeat_cfg = REPEAT_DELAY_MS + REPEAT_RATE_MS;

    assign rep_fire = 1'b0;
`endif

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            o_level   <= level_d;
            o_press   <= press_acc | rep_fire;
            o_release <= release_d;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer paced by a 1 ms tick strobe.
// Optional auto-repeat on held buttons is built when BTN_REPEAT_EN is defined.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEB_MS          = BTN_DEB_MS,
    parameter int REPEAT_DELAY_MS = BTN_REPEAT_DELAY_MS,
    parameter int REPEAT_RATE_MS  = BTN_REPEAT_RATE_MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic [N_BTN-1:0] i_btn,
    output logic [N_BTN-1:0] o_level,
    output logic [N_BTN-1:0] o_press,
    output logic [N_BTN-1:0] o_release
);

    // Independent channels; each drives its own bit of the output vectors.
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        btn_debounce_ch #(
            .DEB_MS          (DEB_MS),
            .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
            .REPEAT_RATE_MS  (REPEAT_RATE_MS)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_tick    (i_tick),
            .i_btn     (i_btn[gi]),
            .o_level   (o_level[gi]),
            .o_press   (o_press[gi]),
            .o_release (o_release[gi])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: vector table plus hand-written corner cases.
module tb_btn_debounce;

    localparam int N = 5;

`ifdef BTN_REPEAT_EN
    localparam int EXP_REPS  = 3;
    localparam int EXP_FIRST = 8;
    localparam int EXP_LAST  = 14;
`else
    localparam int EXP_REPS  = 0;
    localparam int EXP_FIRST = -1;
    localparam int EXP_LAST  = -1;
`endif

    logic         clk;
    logic         rst;
    logic         i_tick;
    logic [N-1:0] i_btn;
    logic [N-1:0] o_level;
    logic [N-1:0] o_press;
    logic [N-1:0] o_release;

    btn_debounce #(
        .N_BTN           (N),
        .DEB_MS          (4),
        .REPEAT_DELAY_MS (8),
        .REPEAT_RATE_MS  (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_tick    (i_tick),
        .i_btn     (i_btn),
        .o_level   (o_level),
        .o_press   (o_press),
        .o_release (o_release)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [N-1:0] btn;
        int           cycles;
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } vec_t;

    int           checks   = 0;
    int           failures = 0;
    int           pc [N];
    int           rc [N];
    logic [N-1:0] lvl_seen;
    logic [N-1:0] prev_press = '0;
    bit           tick_auto  = 1'b1;
    bit           tick_man   = 1'b0;
    int           div        = 0;
    int           tick_num   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clear_cnt();
        for (int i = 0; i < N; i++) begin
            pc[i] = 0;
            rc[i] = 0;
        end
        lvl_seen = '0;
    endtask

    // Advance one clock: drive the tick at the falling edge and observe outputs.
    task automatic cyc();
        @(negedge clk);
        if (tick_auto) begin
            if (div == 9) begin
                div      = 0;
                i_tick   = 1'b1;
                tick_num = tick_num + 1;
            end else begin
                div    = div + 1;
                i_tick = 1'b0;
            end
        end else begin
            i_tick = tick_man;
        end
        for (int i = 0; i < N; i++) begin
            if (o_press[i])   pc[i] = pc[i] + 1;
            if (o_release[i]) rc[i] = rc[i] + 1;
        end
        lvl_seen = lvl_seen | o_level;
        if (|(o_press | o_release)) begin
            chk("pulse_excl",  32'(o_press & o_release), 32'd0);
            chk("press_level", 32'(o_press & ~o_level),  32'd0);
            chk("rel_level",   32'(o_release & o_level), 32'd0);
            chk("press_width", 32'(o_press & prev_press), 32'd0);
        end
        prev_press = o_press;
    endtask

    vec_t         vecs [12];
    logic [N-1:0] got_p;
    logic [N-1:0] got_r;
    logic         extra_p;
    logic         extra_r;
    logic         seen;
    int           t0;
    int           reps;
    int           first_rep;
    int           last_rep;
    int           guard;
    int           post;

    initial begin
        vecs[0]  = '{5'b00000, 30, 5'b00000, 5'b00000, 5'b00000};
        vecs[1]  = '{5'b00001, 50, 5'b00001, 5'b00001, 5'b00000};
        vecs[2]  = '{5'b00000, 50, 5'b00000, 5'b00000, 5'b00001};
        vecs[3]  = '{5'b10100, 50, 5'b10100, 5'b10100, 5'b00000};
        vecs[4]  = '{5'b00100, 50, 5'b00100, 5'b00000, 5'b10000};
        vecs[5]  = '{5'b00000, 50, 5'b00000, 5'b00000, 5'b00100};
        vecs[6]  = '{5'b00010, 20, 5'b00000, 5'b00000, 5'b00000};
        vecs[7]  = '{5'b00000, 30, 5'b00000, 5'b00000, 5'b00000};
        vecs[8]  = '{5'b11111, 50, 5'b11111, 5'b11111, 5'b00000};
        vecs[9]  = '{5'b11111, 30, 5'b11111, 5'b00000, 5'b00000};
        vecs[10] = '{5'b00000, 50, 5'b00000, 5'b00000, 5'b11111};
        vecs[11] = '{5'b00000, 30, 5'b00000, 5'b00000, 5'b00000};

        rst    = 1'b1;
        i_btn  = '0;
        i_tick = 1'b0;
        clear_cnt();
        repeat (5) cyc();
        chk("reset_level",   32'(o_level),   32'd0);
        chk("reset_press",   32'(o_press),   32'd0);
        chk("reset_release", 32'(o_release), 32'd0);
        rst = 1'b0;

        // Table-driven steps: hold a pattern, then compare level and pulse masks.
        for (int v = 0; v < 12; v++) begin
            clear_cnt();
            i_btn = vecs[v].btn;
            repeat (vecs[v].cycles) cyc();
            got_p   = '0;
            got_r   = '0;
            extra_p = 1'b0;
            extra_r = 1'b0;
            for (int i = 0; i < N; i++) begin
                got_p[i] = (pc[i] == 1);
                got_r[i] = (rc[i] == 1);
                if (pc[i] > 1) extra_p = 1'b1;
                if (rc[i] > 1) extra_r = 1'b1;
            end
            chk($sformatf("v%0d_level", v), 32'(o_level), 32'(vecs[v].level));
            chk($sformatf("v%0d_press", v), 32'({extra_p, got_p}), 32'({1'b0, vecs[v].press}));
            chk($sformatf("v%0d_rel", v),   32'({extra_r, got_r}), 32'({1'b0, vecs[v].rel}));
        end

        // Bounce rejection: channel 1 toggles every 15 clocks.
        clear_cnt();
        for (int k = 0; k < 200; k++) begin
            if (k % 15 == 0) i_btn[1] = ~i_btn[1];
            cyc();
        end
        i_btn = '0;
        repeat (30) cyc();
        chk("bounce_level",   32'(lvl_seen[1]), 32'd0);
        chk("bounce_press",   32'(pc[1]),       32'd0);
        chk("bounce_release", 32'(rc[1]),       32'd0);

        // Tick/bounce collision: synchronised drop coincides with the 4th tick.
        clear_cnt();
        tick_auto = 1'b0;
        tick_man  = 1'b0;
        cyc();
        i_btn[1] = 1'b1;
        cyc();
        cyc();
        repeat (3) begin
            tick_man = 1'b1;
            cyc();
            tick_man = 1'b0;
            cyc();
        end
        chk("coll_cnt_before", 32'(dut.g_ch[1].u_ch.cnt_q), 32'd3);
        chk("coll_no_early",   32'(pc[1]),                  32'd0);
        i_btn[1] = 1'b0;
        cyc();
        tick_man = 1'b1;
        cyc();
        tick_man = 1'b0;
        cyc();
        chk("coll_cnt_after", 32'(dut.g_ch[1].u_ch.cnt_q), 32'd0);
        chk("coll_press_now", 32'(o_press[1]),             32'd0);
        repeat (10) cyc();
        chk("coll_press_cnt", 32'(pc[1]),    32'd0);
        chk("coll_level",     32'(lvl_seen[1]), 32'd0);
        tick_auto = 1'b1;

        // Reset while channel 2 is held; re-debounce after release of reset.
        clear_cnt();
        i_btn = 5'b00100;
        repeat (50) cyc();
        chk("rst_pre_level", 32'(o_level[2]), 32'd1);
        clear_cnt();
        rst = 1'b1;
        #1;
        chk("rst_async_level",   32'(o_level),   32'd0);
        chk("rst_async_press",   32'(o_press),   32'd0);
        chk("rst_async_release", 32'(o_release), 32'd0);
        repeat (3) cyc();
        chk("rst_no_release", 32'(rc[2]), 32'd0);
        rst = 1'b0;
        clear_cnt();
        repeat (50) cyc();
        chk("rst_repress_cnt",   32'(pc[2]),      32'd1);
        chk("rst_repress_level", 32'(o_level[2]), 32'd1);
        chk("rst_repress_rel",   32'(rc[2]),      32'd0);
        i_btn = '0;
        repeat (50) cyc();

        // Auto-repeat on channel 3, measured in ticks from acceptance.
        clear_cnt();
        i_btn = 5'b01000;
        seen  = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            cyc();
            if (o_press[3]) seen = 1'b1;
        end
        chk("rep_accept", 32'(seen), 32'd1);
        t0        = tick_num;
        reps      = 0;
        first_rep = -1;
        last_rep  = -1;
        guard     = 0;
        post      = 0;
        while (guard < 400 && post < 3) begin
            cyc();
            guard++;
            if (o_press[3]) begin
                reps++;
                if (first_rep < 0) first_rep = tick_num - t0;
                last_rep = tick_num - t0;
            end
            if (tick_num - t0 >= 16) post++;
        end
        chk("rep_timeout", 32'(guard < 400), 32'd1);
        chk("rep_count",   32'(reps),        32'(EXP_REPS));
        chk("rep_first",   32'(first_rep),   32'(EXP_FIRST));
        chk("rep_last",    32'(last_rep),    32'(EXP_LAST));
        chk("rep_total",   32'(pc[3]),       32'(1 + EXP_REPS));
        i_btn = '0;
        repeat (60) cyc();
        chk("rep_release_level", 32'(o_level[3]), 32'd0);
        chk("rep_release_cnt",   32'(rc[3]),      32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Multi-channel push-button debouncer clocked by the system clock and paced by the 1 kHz `i_tick` strobe from the clock divider. It synchronises raw board buttons, filters contact bounce with a per-channel millisecond counter, and presents clean levels plus one-cycle press and release pulses. Game, menu and LCD control logic consume these outputs instead of raw pins.

## Interface
- `N_BTN`, 5: number of button channels.
- `DEB_MS`, 20: required stable time, in ticks, before a transition is accepted; legal range ≥1.
- `REPEAT_DELAY_MS`, 500: ticks held before the first auto-repeat pulse; used only with the repeat feature.
- `REPEAT_RATE_MS`, 100: ticks between subsequent auto-repeat pulses; used only with the repeat feature.
- `clk`  in  1: system clock, 100 MHz.
- `rst`  in  1: asynchronous, active-high reset.
- `i_tick`  in  1: 1 ms strobe, one `clk` wide.
- `i_btn`  in  `N_BTN`: raw, asynchronous, active-high button pins.
- `o_level`  out  `N_BTN`: debounced button state.
- `o_press`  out  `N_BTN`: one-cycle pulse on an accepted press, and on each auto-repeat.
- `o_release`  out  `N_BTN`: one-cycle pulse on an accepted release.

## Operation
- Each bit of `i_btn` passes through a 2-flop synchroniser. `s` denotes the synchronised value.
- Each channel runs an independent FSM with states IDLE, WAIT_PRESS, HELD and WAIT_REL, plus a debounce counter `cnt` of width clog2(`DEB_MS`+1).
- IDLE:
  - If `s`=1, go to WAIT_PRESS with `cnt`=0.
- WAIT_PRESS:
  - If `s`=0, return to IDLE and clear `cnt`.
  - Otherwise, on each tick: if `cnt`==`DEB_MS`-1, go to HELD; else increment `cnt`.
- HELD:
  - If `s`=0, go to WAIT_REL with `cnt`=0.
- WAIT_REL:
  - If `s`=1, return to HELD and clear `cnt`.
  - Otherwise, on each tick: if `cnt`==`DEB_MS`-1, go to IDLE; else increment `cnt`.
- `o_level` is 1 in HELD and WAIT_REL, and 0 in IDLE and WAIT_PRESS.
- `o_press` pulses on the WAIT_PRESS→HELD transition.
- `o_release` pulses on the WAIT_REL→IDLE transition.
- A bounce and a tick in the same cycle: the bounce wins. The state reverts, `cnt` clears, and no increment occurs.
- A transition is accepted after `DEB_MS` ticks observed with `s` continuously stable. Elapsed time is between `DEB_MS`-1 and `DEB_MS` ms.
- Channels never interact. Simultaneous presses on several channels produce simultaneous pulses.
- `i_tick` held high for several cycles counts as one tick per cycle. This is a caller error, and no guarding is provided.

## Timing
- Reset value of every output is 0. All FSMs reset to IDLE, and all counters and synchroniser flops reset to 0.
- Reset asserted mid-operation drops `o_level` immediately (asynchronously) with no release pulse. After reset deassertion, a still-held button is re-debounced from IDLE.
- Synchroniser latency is 2 `clk`.
- `o_press`, `o_release` and `o_level` are registered. They change in the cycle after the `clk` edge on which the confirming tick is sampled.
- `o_press` and `o_release` are exactly 1 `clk` wide. They are never asserted in the same cycle on the same channel.
- `o_level` rises in the same cycle `o_press` is high, and falls in the same cycle `o_release` is high.

## Configuration
- `BTN_REPEAT_EN` enables auto-repeat.
- When defined:
  - In HELD, a repeat counter of width clog2(max(`REPEAT_DELAY_MS`,`REPEAT_RATE_MS`)+1) counts ticks, starting from 0 on entry to HELD.
  - After `REPEAT_DELAY_MS` ticks, `o_press` pulses once more. The counter then reloads, and further pulses follow every `REPEAT_RATE_MS` ticks while the channel stays in HELD.
  - Leaving HELD, including to WAIT_REL, clears the repeat counter. Returning from WAIT_REL to HELD restarts the delay phase.
- When undefined:
  - No repeat logic or counter is synthesised.
  - `o_press` pulses exactly once per accepted press.
  - The `REPEAT_*` parameters are ignored.

## Structure
- The shared package `btn_pkg` holds:
  - the FSM state enum `btn_state_t` with IDLE, WAIT_PRESS, HELD and WAIT_REL;
  - the default constants `BTN_DEB_MS`, `BTN_REPEAT_DELAY_MS` and `BTN_REPEAT_RATE_MS`.
- Sub-module `btn_debounce_ch` implements one channel: synchroniser, FSM, counters and optional repeat.
- The top module `btn_debounce` instantiates `N_BTN` copies in a generate loop and concatenates their outputs.

## Test plan
Bench uses `DEB_MS`=4, `REPEAT_DELAY_MS`=8, `REPEAT_RATE_MS`=3, with `i_tick` every 10 `clk`.
- Clean press: `i_btn[0]` held at 1 for 60 `clk` → exactly one `o_press[0]` pulse within 4 ticks + 3 `clk`; `o_level[0]`=1 afterwards; other channels stay 0.
- Bounce rejection: `i_btn[1]` toggles every 15 `clk` for 200 `clk` → `o_level[1]`, `o_press[1]` and `o_release[1]` stay 0 throughout.
- Release: after an accepted press, drive `i_btn[0]`=0 → one `o_release[0]` pulse after 4 ticks; `o_level[0]`=0; no extra `o_press`.
- Tick/bounce collision: `s` drops in the same cycle as `i_tick` during WAIT_PRESS → `cnt` reads 0 the next cycle; no press occurs.
- Reset mid-hold: assert `rst` while `o_level[2]`=1 → all outputs go to 0 immediately with no `o_release`. Deassert `rst` with the button still held → `o_press[2]` after 4 ticks.
- Repeat (with `BTN_REPEAT_EN` defined): hold `i_btn[3]` for 20 ticks → `o_press[3]` pulses at acceptance, then 8 ticks later, then every 3 ticks. Rebuilt without the macro, the same stimulus gives exactly 1 pulse.
